// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter sharing one memory config port among N_REQ requesters
module mem_port_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ-1:0]   req_wr_rd_s,
  input  logic [8*N_REQ-1:0] req_addr,
  input  logic [8*N_REQ-1:0] req_wr_data,
  output logic [N_REQ-1:0]   req_done,
  output logic [N_REQ-1:0]   req_err,
  output logic [7:0]         req_rd_data,
  output logic               mem_sel_en,
  output logic [7:0]         mem_addr,
  output logic [7:0]         mem_wr_data,
  output logic               mem_wr_rd_s,
  input  logic [7:0]         mem_rd_data,
  input  logic               mem_ack
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int SW = IW + 1;
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_REQ - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] gnt_idx;
  logic [IW-1:0] pick_idx;
  logic [IW-1:0] gnt_next_ptr;
  logic          pick_found;
  logic [SW-1:0] cand_sum;
  logic [IW-1:0] cand_idx;
  logic [CW-1:0] cnt;
  logic          grant;
  logic          finish;
  logic          timed_out;

  // Pointer handed to the arbiter after an access: one past the granted requester, wrapping.
  assign gnt_next_ptr = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;

  // Round-robin search: first requester with req_valid set, starting at rr_ptr and wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand_sum   = '0;
    cand_idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand_sum = {1'b0, rr_ptr} + SW'(i);
      if (cand_sum >= SW'(N_REQ)) begin
        cand_sum = cand_sum - SW'(N_REQ);
      end
      cand_idx = cand_sum[IW-1:0];
      if (!pick_found && req_valid[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  // Next-state and per-edge strobes; an ack beats a coincident timeout.
  always_comb begin
    state_next = state;
    grant      = 1'b0;
    finish     = 1'b0;
    timed_out  = 1'b0;
    case (state)
      IDLE: begin
        if (pick_found) begin
          grant      = 1'b1;
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        if (mem_ack) begin
          finish     = 1'b1;
          state_next = RELEASE;
        end else if (cnt == CNT_LAST) begin
          finish     = 1'b1;
          timed_out  = 1'b1;
          state_next = RELEASE;
        end
      end
      RELEASE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Datapath: latch the granted request, drive the memory port, report completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr      <= '0;
      gnt_idx     <= '0;
      cnt         <= '0;
      mem_sel_en  <= 1'b0;
      mem_addr    <= '0;
      mem_wr_data <= '0;
      mem_wr_rd_s <= 1'b0;
      req_done    <= '0;
      req_err     <= '0;
      req_rd_data <= '0;
    end else begin
      req_done    <= '0;
      req_err     <= '0;
      req_rd_data <= '0;
      if (grant) begin
        gnt_idx     <= pick_idx;
        mem_addr    <= req_addr[{pick_idx, 3'b000} +: 8];
        mem_wr_data <= req_wr_data[{pick_idx, 3'b000} +: 8];
        mem_wr_rd_s <= req_wr_rd_s[pick_idx];
        mem_sel_en  <= 1'b1;
        cnt         <= '0;
      end
      if (state == ACCESS) begin
        cnt <= cnt + 1'b1;
      end
      if (finish) begin
        mem_sel_en        <= 1'b0;
        req_done[gnt_idx] <= 1'b1;
        req_err[gnt_idx]  <= timed_out;
        req_rd_data       <= (timed_out || mem_wr_rd_s) ? 8'h00 : mem_rd_data;
        rr_ptr            <= gnt_next_ptr;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int N  = 4;
  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_wr_rd_s;
  logic [8*N-1:0] req_addr;
  logic [8*N-1:0] req_wr_data;
  logic [N-1:0]   req_done;
  logic [N-1:0]   req_err;
  logic [7:0]     req_rd_data;
  logic           mem_sel_en;
  logic [7:0]     mem_addr;
  logic [7:0]     mem_wr_data;
  logic           mem_wr_rd_s;
  logic [7:0]     mem_rd_data;
  logic           mem_ack;

  int checks   = 0;
  int failures = 0;

  // Model of the requesters' view used by the randomized test.
  int         rr_m;
  logic [N-1:0] m_v;
  logic       m_w [N];
  logic [7:0] m_a [N];
  logic [7:0] m_d [N];

  mem_port_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_wr_rd_s (req_wr_rd_s),
    .req_addr    (req_addr),
    .req_wr_data (req_wr_data),
    .req_done    (req_done),
    .req_err     (req_err),
    .req_rd_data (req_rd_data),
    .mem_sel_en  (mem_sel_en),
    .mem_addr    (mem_addr),
    .mem_wr_data (mem_wr_data),
    .mem_wr_rd_s (mem_wr_rd_s),
    .mem_rd_data (mem_rd_data),
    .mem_ack     (mem_ack)
  );

  always #5 clk = ~clk;

  task automatic obs();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic w, input logic [7:0] a, input logic [7:0] d);
    req_valid[i]         = 1'b1;
    req_wr_rd_s[i]       = w;
    req_addr[i*8 +: 8]    = a;
    req_wr_data[i*8 +: 8] = d;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    req_valid   = '0;
    req_wr_rd_s = '0;
    req_addr    = '0;
    req_wr_data = '0;
    mem_ack     = 1'b0;
    mem_rd_data = '0;
    obs();
    obs();
    rst_n = 1'b1;
  endtask

  // Plays the memory side for one access: waits for mem_sel_en, acks on high cycle d
  // (d > TO means never), and reports what was seen. Returns one cycle after the done cycle.
  task automatic run_access(input int d, input logic [7:0] rdv, input logic [N-1:0] drop,
                            input logic [N-1:0] scram, output int wait_n, output int hi_n,
                            output logic [7:0] a, output logic [7:0] wd, output logic w,
                            output logic stable, output logic [N-1:0] dn, output logic [N-1:0] er,
                            output logic [7:0] rd, output logic [N-1:0] dn_next);
    wait_n = 0; hi_n = 0; stable = 1'b1; a = '0; wd = '0; w = 1'b0;
    dn = '0; er = '0; rd = '0; dn_next = '0;
    do begin
      obs();
      wait_n++;
      if (!mem_sel_en) begin
        mem_ack     = 1'($urandom_range(0, 1));
        mem_rd_data = 8'($urandom);
      end
    end while (!mem_sel_en && wait_n < 20);
    if (!mem_sel_en) return;
    a = mem_addr; wd = mem_wr_data; w = mem_wr_rd_s; hi_n = 1;
    while (mem_sel_en && hi_n <= TO + 2) begin
      if (mem_addr !== a || mem_wr_data !== wd || mem_wr_rd_s !== w || req_done !== '0) stable = 1'b0;
      mem_ack     = (hi_n == d);
      mem_rd_data = (hi_n == d) ? rdv : 8'($urandom);
      for (int i = 0; i < N; i++) begin
        if (scram[i]) begin
          req_addr[i*8 +: 8]    = 8'($urandom);
          req_wr_data[i*8 +: 8] = 8'($urandom);
          req_wr_rd_s[i]        = 1'($urandom_range(0, 1));
        end
      end
      obs();
      if (mem_sel_en) hi_n++;
    end
    dn = req_done; er = req_err; rd = req_rd_data;
    req_valid   = req_valid & ~drop;
    mem_ack     = 1'($urandom_range(0, 1));
    mem_rd_data = 8'($urandom);
    obs();
    dn_next = req_done;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 4'b1111;
    #1;
    checks++; if (mem_sel_en !== 1'b0) begin failures++; $display("FAIL reset_sel got=%b exp=0", mem_sel_en); end
    obs();
    obs();
    checks++; if (req_done !== '0 || req_err !== '0) begin failures++; $display("FAIL reset_done got=%b/%b exp=0", req_done, req_err); end
    checks++; if (req_rd_data !== 8'h00 || mem_addr !== 8'h00 || mem_wr_data !== 8'h00 || mem_wr_rd_s !== 1'b0) begin
      failures++; $display("FAIL reset_outs rd=%h addr=%h wd=%h w=%b exp=0", req_rd_data, mem_addr, mem_wr_data, mem_wr_rd_s); end
    checks++; if (mem_sel_en !== 1'b0) begin failures++; $display("FAIL reset_sel_hold got=%b exp=0", mem_sel_en); end
    do_reset();
  endtask

  task automatic test_single_write();
    int wn, hn; logic [7:0] a, wd, rd; logic w, st; logic [N-1:0] dn, er, dn2;
    set_req(0, 1'b1, 8'h12, 8'hA5);
    run_access(3, 8'h77, 4'b0001, 4'b0001, wn, hn, a, wd, w, st, dn, er, rd, dn2);
    checks++; if (wn !== 1) begin failures++; $display("FAIL wr_latency got=%0d exp=1", wn); end
    checks++; if (hn !== 3) begin failures++; $display("FAIL wr_sel_len got=%0d exp=3", hn); end
    checks++; if (a !== 8'h12 || wd !== 8'hA5 || w !== 1'b1) begin failures++; $display("FAIL wr_fields got=%h/%h/%b exp=12/a5/1", a, wd, w); end
    checks++; if (st !== 1'b1) begin failures++; $display("FAIL wr_stable got=%b exp=1", st); end
    checks++; if (dn !== 4'b0001 || er !== 4'b0000) begin failures++; $display("FAIL wr_done got=%b err=%b exp=0001/0000", dn, er); end
    checks++; if (rd !== 8'h00) begin failures++; $display("FAIL wr_rd_data got=%h exp=00", rd); end
    checks++; if (dn2 !== 4'b0000) begin failures++; $display("FAIL wr_done_width got=%b exp=0000", dn2); end
  endtask

  task automatic test_single_read();
    int wn, hn; logic [7:0] a, wd, rd; logic w, st; logic [N-1:0] dn, er, dn2;
    set_req(2, 1'b0, 8'h40, 8'h00);
    run_access(2, 8'h3C, 4'b0100, 4'b0000, wn, hn, a, wd, w, st, dn, er, rd, dn2);
    checks++; if (a !== 8'h40 || w !== 1'b0 || hn !== 2) begin failures++; $display("FAIL rd_fields addr=%h w=%b len=%0d exp=40/0/2", a, w, hn); end
    checks++; if (dn !== 4'b0100 || er !== 4'b0000) begin failures++; $display("FAIL rd_done got=%b err=%b exp=0100/0000", dn, er); end
    checks++; if (rd !== 8'h3C) begin failures++; $display("FAIL rd_data got=%h exp=3c", rd); end
    checks++; if (mem_sel_en !== 1'b0) begin failures++; $display("FAIL rd_sel_after got=%b exp=0", mem_sel_en); end
  endtask

  task automatic test_round_robin();
    int wn, hn; logic [7:0] a, wd, rd; logic w, st; logic [N-1:0] dn, er, dn2;
    int exp_k;
    rst_n = 1'b0;
    mem_ack = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 8'(8'h80 + i), 8'h00);
    obs();
    rst_n = 1'b1;
    for (int n = 0; n < 5; n++) begin
      exp_k = n % N;
      run_access(1, 8'(n), 4'b0000, 4'b0000, wn, hn, a, wd, w, st, dn, er, rd, dn2);
      checks++; if (a !== 8'(8'h80 + exp_k) || wn !== 1) begin
        failures++; $display("FAIL rr_grant%0d addr=%h wait=%0d exp=%h/1", n, a, wn, 8'(8'h80 + exp_k)); end
      checks++; if (dn !== 4'(1 << exp_k) || rd !== 8'(n)) begin
        failures++; $display("FAIL rr_done%0d got=%b rd=%h exp=%b/%h", n, dn, rd, 4'(1 << exp_k), 8'(n)); end
    end
    req_valid = '0;
    obs();
  endtask

  task automatic test_timeout();
    int wn, hn; logic [7:0] a, wd, rd; logic w, st; logic [N-1:0] dn, er, dn2;
    set_req(1, 1'b0, 8'h07, 8'h00);
    run_access(1000, 8'hEE, 4'b0010, 4'b0000, wn, hn, a, wd, w, st, dn, er, rd, dn2);
    checks++; if (hn !== TO) begin failures++; $display("FAIL to_sel_len got=%0d exp=%0d", hn, TO); end
    checks++; if (dn !== 4'b0010 || er !== 4'b0010) begin failures++; $display("FAIL to_done got=%b err=%b exp=0010/0010", dn, er); end
    checks++; if (rd !== 8'h00 || dn2 !== 4'b0000) begin failures++; $display("FAIL to_rd got=%h next=%b exp=00/0000", rd, dn2); end
    set_req(0, 1'b1, 8'h55, 8'h66);
    run_access(2, 8'h11, 4'b0001, 4'b0000, wn, hn, a, wd, w, st, dn, er, rd, dn2);
    checks++; if (wn !== 1 || hn !== 2 || a !== 8'h55 || dn !== 4'b0001 || er !== 4'b0000) begin
      failures++; $display("FAIL to_next wait=%0d len=%0d addr=%h done=%b err=%b exp=1/2/55/0001/0000", wn, hn, a, dn, er); end
  endtask

  task automatic test_ack_last();
    int wn, hn; logic [7:0] a, wd, rd; logic w, st; logic [N-1:0] dn, er, dn2;
    set_req(3, 1'b0, 8'h99, 8'h00);
    run_access(TO, 8'hC3, 4'b1000, 4'b0000, wn, hn, a, wd, w, st, dn, er, rd, dn2);
    checks++; if (hn !== TO) begin failures++; $display("FAIL last_len got=%0d exp=%0d", hn, TO); end
    checks++; if (dn !== 4'b1000 || er !== 4'b0000 || rd !== 8'hC3) begin
      failures++; $display("FAIL last_ack done=%b err=%b rd=%h exp=1000/0000/c3", dn, er, rd); end
  endtask

  task automatic test_reset_mid();
    int wn, hn, n; logic [7:0] a, wd, rd; logic w, st; logic [N-1:0] dn, er, dn2;
    set_req(1, 1'b1, 8'h21, 8'h00);
    run_access(1, 8'h00, 4'b0010, 4'b0000, wn, hn, a, wd, w, st, dn, er, rd, dn2);
    set_req(0, 1'b0, 8'h10, 8'h00);
    set_req(3, 1'b0, 8'h33, 8'h00);
    mem_ack = 1'b0;
    n = 0;
    do begin obs(); n++; end while (!mem_sel_en && n < 10);
    checks++; if (mem_sel_en !== 1'b1 || mem_addr !== 8'h33) begin
      failures++; $display("FAIL mid_pre_grant sel=%b addr=%h exp=1/33", mem_sel_en, mem_addr); end
    obs();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (mem_sel_en !== 1'b0 || req_done !== '0) begin
      failures++; $display("FAIL mid_async sel=%b done=%b exp=0/0000", mem_sel_en, req_done); end
    obs();
    obs();
    checks++; if (req_done !== '0 || req_err !== '0) begin failures++; $display("FAIL mid_no_done got=%b exp=0000", req_done); end
    rst_n = 1'b1;
    run_access(1, 8'h00, 4'b0001, 4'b0000, wn, hn, a, wd, w, st, dn, er, rd, dn2);
    checks++; if (a !== 8'h10 || wn !== 1 || dn !== 4'b0001) begin
      failures++; $display("FAIL mid_regrant addr=%h wait=%0d done=%b exp=10/1/0001", a, wn, dn); end
    run_access(1, 8'h00, 4'b1000, 4'b0000, wn, hn, a, wd, w, st, dn, er, rd, dn2);
    checks++; if (a !== 8'h33 || dn !== 4'b1000) begin failures++; $display("FAIL mid_second addr=%h done=%b exp=33/1000", a, dn); end
  endtask

  task automatic new_req(input int i);
    m_v[i] = 1'b1;
    m_w[i] = 1'($urandom_range(0, 1));
    m_a[i] = 8'($urandom);
    m_d[i] = 8'($urandom);
    set_req(i, m_w[i], m_a[i], m_d[i]);
  endtask

  task automatic test_random();
    int wn, hn, k, d, exp_len, r; logic [7:0] a, wd, rd, rdv, exp_rd; logic w, st, keep;
    logic [N-1:0] dn, er, dn2, onehot, exp_er;
    do_reset();
    rr_m = 0;
    m_v  = '0;
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < N; i++) if (!m_v[i] && $urandom_range(0, 3) == 0) new_req(i);
      if (m_v == '0) new_req($urandom_range(0, N - 1));
      k = -1;
      for (int i = 0; i < N; i++) if (k < 0 && m_v[(rr_m + i) % N]) k = (rr_m + i) % N;
      onehot = '0; onehot[k] = 1'b1;
      r = $urandom_range(0, 5);
      d = (r == 0) ? TO : (r == 1) ? TO + 1 + $urandom_range(0, 3) : $urandom_range(1, 6);
      rdv  = 8'($urandom);
      keep = 1'($urandom_range(0, 1));
      run_access(d, rdv, keep ? 4'b0000 : onehot, onehot, wn, hn, a, wd, w, st, dn, er, rd, dn2);
      exp_len = (d <= TO) ? d : TO;
      exp_er  = (d <= TO) ? 4'b0000 : onehot;
      exp_rd  = (d <= TO && !m_w[k]) ? rdv : 8'h00;
      checks++; if (wn !== 1) begin failures++; $display("FAIL rnd%0d_latency got=%0d exp=1", it, wn); end
      checks++; if (a !== m_a[k] || wd !== m_d[k] || w !== m_w[k]) begin
        failures++; $display("FAIL rnd%0d_fields got=%h/%h/%b exp=%h/%h/%b (req %0d)", it, a, wd, w, m_a[k], m_d[k], m_w[k], k); end
      checks++; if (st !== 1'b1) begin failures++; $display("FAIL rnd%0d_stable got=%b exp=1", it, st); end
      checks++; if (hn !== exp_len) begin failures++; $display("FAIL rnd%0d_len got=%0d exp=%0d", it, hn, exp_len); end
      checks++; if (dn !== onehot || er !== exp_er) begin
        failures++; $display("FAIL rnd%0d_done got=%b err=%b exp=%b/%b", it, dn, er, onehot, exp_er); end
      checks++; if (rd !== exp_rd) begin failures++; $display("FAIL rnd%0d_rd got=%h exp=%h", it, rd, exp_rd); end
      checks++; if (dn2 !== '0) begin failures++; $display("FAIL rnd%0d_done_width got=%b exp=0000", it, dn2); end
      rr_m = (k + 1) % N;
      if (keep) new_req(k);
      else m_v[k] = 1'b0;
    end
    req_valid = '0;
    obs();
  endtask

  initial begin
    rst_n       = 1'b0;
    req_valid   = '0;
    req_wr_rd_s = '0;
    req_addr    = '0;
    req_wr_data = '0;
    mem_ack     = 1'b0;
    mem_rd_data = '0;
    test_reset();
    test_single_write();
    test_single_read();
    test_round_robin();
    test_timeout();
    test_ack_last();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
